// File: rtl/hazard_scoreboard_if.sv
// ID-stage decode bundle into the hazard scoreboard and the stall/debug
// signals it returns to the controller.
interface hazard_scoreboard_if #(
   parameter int RW = 5,
   parameter int CW = 6
);
   logic          id_valid;
   logic          flush;
   logic [RW-1:0] id_rs;
   logic [RW-1:0] id_rt;
   logic          id_use_rs;
   logic          id_use_rt;
   logic          id_early;
   logic          id_store_rt;
   logic          id_regwrite;
   logic [RW-1:0] id_rw;
   logic [1:0]    id_class;
   logic          id_reads_hilo;
   logic          stall;
   logic [1:0]    stall_reason;
   logic          md_busy;
   logic [CW-1:0] md_cnt_o;

   modport master (
      output id_valid, flush, id_rs, id_rt, id_use_rs, id_use_rt, id_early,
             id_store_rt, id_regwrite, id_rw, id_class, id_reads_hilo,
      input  stall, stall_reason, md_busy, md_cnt_o
   );

   modport slave (
      input  id_valid, flush, id_rs, id_rt, id_use_rs, id_use_rt, id_early,
             id_store_rt, id_regwrite, id_rw, id_class, id_reads_hilo,
      output stall, stall_reason, md_busy, md_cnt_o
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Latency-driven ID-stage stall generator: per-GPR countdown scoreboard plus
// a HI/LO multiply/divide occupancy counter.
module hazard_scoreboard #(
   parameter int NREG     = 32,
   parameter int RW       = $clog2(NREG),
   parameter int LOAD_LAT = 2,
   parameter int MUL_LAT  = 5,
   parameter int DIV_LAT  = 32,
   parameter int CW       = $clog2(((LOAD_LAT > MUL_LAT)
                                    ? ((LOAD_LAT > DIV_LAT) ? LOAD_LAT : DIV_LAT)
                                    : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT)) + 1)
)(
   input logic            clk,
   input logic            rst,
   hazard_scoreboard_if.slave sb
);

   localparam logic [1:0]    CLASS_ALU  = 2'd0;
   localparam logic [1:0]    CLASS_LOAD = 2'd1;
   localparam logic [1:0]    CLASS_MUL  = 2'd2;
   localparam logic [1:0]    CLASS_DIV  = 2'd3;
   localparam logic [CW-1:0] ZERO_C     = {CW{1'b0}};
   localparam logic [CW-1:0] ONE_C      = CW'(1);
   localparam logic [CW-1:0] LOAD_C     = CW'(LOAD_LAT);
   localparam logic [CW-1:0] MUL_C      = CW'(MUL_LAT);
   localparam logic [CW-1:0] DIV_C      = CW'(DIV_LAT);
   localparam logic [RW-1:0] R0_C       = {RW{1'b0}};

   logic [CW-1:0] cnt_r [1:NREG-1];
   logic [CW-1:0] md_cnt_r;

   logic [CW-1:0] rs_cnt_s;
   logic [CW-1:0] rt_cnt_s;
   logic [CW-1:0] rs_thr_s;
   logic [CW-1:0] rt_thr_s;
   logic          rs_haz_s;
   logic          rt_haz_s;
   logic          gpr_haz_s;
   logic          hilo_haz_s;
   logic          md_op_s;
   logic          md_busy_s;
   logic          live_s;
   logic          stall_s;
   logic          issue_s;
   logic          gpr_wr_s;
   logic [CW-1:0] gpr_val_s;
   logic [CW-1:0] md_val_s;

   // Look up the scoreboard entries of both sources; index 0 reads as idle.
   always_comb begin
      rs_cnt_s = ZERO_C;
      rt_cnt_s = ZERO_C;
      for (int i = 1; i < NREG; i++) begin
         rs_cnt_s = (sb.id_rs == RW'(i)) ? cnt_r[i] : rs_cnt_s;
         rt_cnt_s = (sb.id_rt == RW'(i)) ? cnt_r[i] : rt_cnt_s;
      end
   end

   // Hazard thresholds, stall decision and producer write values.
   always_comb begin
      // A store's data operand can wait for the MEM bypass, so only a load
      // still further back than EX blocks it.
      rs_thr_s   = sb.id_early ? ZERO_C : ONE_C;
      rt_thr_s   = sb.id_early ? ZERO_C : (sb.id_store_rt ? LOAD_C : ONE_C);
      rs_haz_s   = sb.id_use_rs & (sb.id_rs != R0_C) & (rs_cnt_s > rs_thr_s);
      rt_haz_s   = sb.id_use_rt & (sb.id_rt != R0_C) & (rt_cnt_s > rt_thr_s);
      gpr_haz_s  = rs_haz_s | rt_haz_s;
      md_op_s    = (sb.id_class == CLASS_MUL) | (sb.id_class == CLASS_DIV);
      md_busy_s  = (md_cnt_r != ZERO_C);
      hilo_haz_s = md_busy_s & (sb.id_reads_hilo | md_op_s);
      live_s     = sb.id_valid & ~sb.flush;
      stall_s    = live_s & (gpr_haz_s | hilo_haz_s);
      issue_s    = live_s & ~stall_s;
      gpr_wr_s   = issue_s & sb.id_regwrite & ~md_op_s & (sb.id_rw != R0_C);
      gpr_val_s  = (sb.id_class == CLASS_LOAD) ? LOAD_C : ONE_C;
      md_val_s   = (sb.id_class == CLASS_MUL) ? MUL_C : DIV_C;
   end

   // GPR scoreboard: issue write has priority over the per-cycle countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NREG; i++) begin
            cnt_r[i] <= ZERO_C;
         end
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (gpr_wr_s && (sb.id_rw == RW'(i))) begin
               cnt_r[i] <= gpr_val_s;
            end else if (cnt_r[i] != ZERO_C) begin
               cnt_r[i] <= cnt_r[i] - ONE_C;
            end else begin
               cnt_r[i] <= ZERO_C;
            end
         end
      end
   end

   // HI/LO occupancy; flush never cancels an MD op already issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         md_cnt_r <= ZERO_C;
      end else if (issue_s && md_op_s) begin
         md_cnt_r <= md_val_s;
      end else if (md_cnt_r != ZERO_C) begin
         md_cnt_r <= md_cnt_r - ONE_C;
      end else begin
         md_cnt_r <= ZERO_C;
      end
   end

   assign sb.stall        = stall_s;
   assign sb.stall_reason = {live_s & hilo_haz_s, live_s & gpr_haz_s};
   assign sb.md_busy      = md_busy_s;
   assign sb.md_cnt_o     = md_cnt_r;

   // Keep the class encoding documented in one place.
   logic unused_alu_s;
   assign unused_alu_s = (sb.id_class == CLASS_ALU);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, store bypass, early
// consumers, r0, HI/LO serialisation, flush and asynchronous reset.
module tb_hazard_scoreboard;

   logic clk = 1'b0;
   logic rst;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.RW(5), .CW(6)) sb();

   hazard_scoreboard dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb)
   );

   task automatic idle();
      sb.id_valid      = 1'b0;
      sb.flush         = 1'b0;
      sb.id_rs         = 5'd0;
      sb.id_rt         = 5'd0;
      sb.id_use_rs     = 1'b0;
      sb.id_use_rt     = 1'b0;
      sb.id_early      = 1'b0;
      sb.id_store_rt   = 1'b0;
      sb.id_regwrite   = 1'b0;
      sb.id_rw         = 5'd0;
      sb.id_class      = 2'd0;
      sb.id_reads_hilo = 1'b0;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_rs, input logic use_rt,
                        input logic early, input logic store_rt,
                        input logic regwrite, input logic [4:0] rw,
                        input logic [1:0] cls, input logic hilo);
      sb.id_valid      = 1'b1;
      sb.flush         = 1'b0;
      sb.id_rs         = rs;
      sb.id_rt         = rt;
      sb.id_use_rs     = use_rs;
      sb.id_use_rt     = use_rt;
      sb.id_early      = early;
      sb.id_store_rt   = store_rt;
      sb.id_regwrite   = regwrite;
      sb.id_rw         = rw;
      sb.id_class      = cls;
      sb.id_reads_hilo = hilo;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold the current ID instruction until it issues; report stall cycles
   // and whether every stalled cycle showed the given reason with md_busy as given.
   task automatic wait_issue(input logic [1:0] exp_reason, input logic exp_busy,
                             output int n, output bit ok);
      n  = 0;
      ok = 1'b1;
      while (sb.stall === 1'b1 && n < 64) begin
         if (sb.stall_reason !== exp_reason || sb.md_busy !== exp_busy) ok = 1'b0;
         step();
         n++;
      end
      step();
      idle();
      #1;
   endtask

   task automatic test_reset();
      total++; if (sb.stall !== 1'b0) $display("FAIL reset_stall got %b want 0", sb.stall); else passed++;
      total++; if (sb.stall_reason !== 2'b00) $display("FAIL reset_reason got %b want 00", sb.stall_reason); else passed++;
      total++; if (sb.md_busy !== 1'b0) $display("FAIL reset_md_busy got %b want 0", sb.md_busy); else passed++;
      total++; if (sb.md_cnt_o !== 6'd0) $display("FAIL reset_md_cnt got %0d want 0", sb.md_cnt_o); else passed++;
      drive(5'd3, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 2'd0, 1'b0);
      total++; if (sb.stall !== 1'b0) $display("FAIL reset_cnt_clear got %b want 0", sb.stall); else passed++;
      idle();
      step();
   endtask

   task automatic test_load_use();
      drive(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 2'd1, 1'b0);
      total++; if (sb.stall !== 1'b0) $display("FAIL lu_producer got %b want 0", sb.stall); else passed++;
      step();
      drive(5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 2'd0, 1'b0);
      total++; if (sb.stall !== 1'b1) $display("FAIL lu_stall got %b want 1", sb.stall); else passed++;
      total++; if (sb.stall_reason !== 2'b01) $display("FAIL lu_reason got %b want 01", sb.stall_reason); else passed++;
      step();
      total++; if (sb.stall !== 1'b0) $display("FAIL lu_release got %b want 0", sb.stall); else passed++;
      step();
      idle();
      repeat (3) step();
   endtask

   task automatic test_load_store();
      drive(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 2'd1, 1'b0);
      step();
      drive(5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
      total++; if (sb.stall !== 1'b0) $display("FAIL ls_store got %b want 0", sb.stall); else passed++;
      step();
      // Same rt read as a normal operand one cycle later must not stall.
      drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 2'd0, 1'b0);
      total++; if (sb.stall !== 1'b0) $display("FAIL ls_after got %b want 0", sb.stall); else passed++;
      step();
      idle();
      repeat (3) step();
   endtask

   task automatic test_early();
      int n;
      bit ok;
      drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 2'd0, 1'b0);
      step();
      drive(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
      wait_issue(2'b01, 1'b0, n, ok);
      total++; if (n !== 1 || !ok) $display("FAIL early_alu got %0d cycles ok=%0d want 1 ok=1", n, ok); else passed++;
      repeat (3) step();
      drive(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 2'd1, 1'b0);
      step();
      drive(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
      wait_issue(2'b01, 1'b0, n, ok);
      total++; if (n !== 2 || !ok) $display("FAIL early_load got %0d cycles ok=%0d want 2 ok=1", n, ok); else passed++;
      repeat (3) step();
      drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 2'd0, 1'b0);
      step();
      drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 2'd0, 1'b0);
      total++; if (sb.stall !== 1'b0) $display("FAIL alu_nonearly got %b want 0", sb.stall); else passed++;
      step();
      idle();
      repeat (3) step();
   endtask

   task automatic test_r0();
      drive(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 2'd1, 1'b0);
      step();
      drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 2'd0, 1'b0);
      total++; if (sb.stall !== 1'b0) $display("FAIL r0_add got %b want 0", sb.stall); else passed++;
      sb.id_early = 1'b1;
      #1;
      total++; if (sb.stall !== 1'b0) $display("FAIL r0_early got %b want 0", sb.stall); else passed++;
      step();
      idle();
      repeat (3) step();
   endtask

   task automatic test_md();
      int n;
      bit ok;
      drive(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'd3, 1'b0);
      step();
      total++; if (sb.md_busy !== 1'b1 || sb.md_cnt_o !== 6'd32) $display("FAIL md_div_start got busy=%b cnt=%0d want busy=1 cnt=32", sb.md_busy, sb.md_cnt_o); else passed++;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 2'd0, 1'b1);
      wait_issue(2'b10, 1'b1, n, ok);
      total++; if (n !== 32 || !ok) $display("FAIL md_mflo got %0d cycles ok=%0d want 32 ok=1", n, ok); else passed++;
      total++; if (sb.md_busy !== 1'b0) $display("FAIL md_done got %b want 0", sb.md_busy); else passed++;
      drive(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'd3, 1'b0);
      step();
      drive(5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 2'd2, 1'b0);
      wait_issue(2'b10, 1'b1, n, ok);
      total++; if (n !== 32 || !ok) $display("FAIL md_mult_after_div got %0d cycles ok=%0d want 32 ok=1", n, ok); else passed++;
      total++; if (sb.md_cnt_o !== 6'd5) $display("FAIL md_mult_cnt got %0d want 5", sb.md_cnt_o); else passed++;
      // Second mult meets md_cnt=1 on its last stall cycle and issues right after.
      drive(5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'd2, 1'b0);
      wait_issue(2'b10, 1'b1, n, ok);
      total++; if (n !== 5 || !ok) $display("FAIL md_back_to_back got %0d cycles ok=%0d want 5 ok=1", n, ok); else passed++;
      repeat (6) step();
   endtask

   task automatic test_flush();
      drive(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'd3, 1'b0);
      step();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 2'd0, 1'b1);
      sb.flush = 1'b1;
      #1;
      total++; if (sb.stall !== 1'b0 || sb.stall_reason !== 2'b00) $display("FAIL flush_stall got %b/%b want 0/00", sb.stall, sb.stall_reason); else passed++;
      step();
      total++; if (sb.md_cnt_o !== 6'd31) $display("FAIL flush_md_keeps got %0d want 31", sb.md_cnt_o); else passed++;
      drive(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 2'd1, 1'b0);
      sb.flush = 1'b1;
      step();
      drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
      total++; if (sb.stall !== 1'b0) $display("FAIL flush_no_write got %b want 0", sb.stall); else passed++;
      step();
      idle();
      repeat (32) step();
   endtask

   task automatic test_async_reset();
      drive(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'd3, 1'b0);
      step();
      idle();
      repeat (14) step();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 2'd1, 1'b0);
      step();
      total++; if (sb.md_cnt_o !== 6'd17) $display("FAIL ar_md_cnt got %0d want 17", sb.md_cnt_o); else passed++;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 2'd0, 1'b1);
      total++; if (sb.stall !== 1'b1) $display("FAIL ar_pre_stall got %b want 1", sb.stall); else passed++;
      #2 rst = 1'b1;
      #1;
      total++; if (sb.md_busy !== 1'b0 || sb.md_cnt_o !== 6'd0) $display("FAIL ar_md_clear got busy=%b cnt=%0d want 0/0", sb.md_busy, sb.md_cnt_o); else passed++;
      total++; if (sb.stall !== 1'b0 || sb.stall_reason !== 2'b00) $display("FAIL ar_stall_clear got %b/%b want 0/00", sb.stall, sb.stall_reason); else passed++;
      #1 rst = 1'b0;
      drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
      total++; if (sb.stall !== 1'b0) $display("FAIL ar_first_issue got %b want 0", sb.stall); else passed++;
      step();
      idle();
      step();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      test_reset();
      test_load_use();
      test_load_store();
      test_early();
      test_r0();
      test_md();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the fixed-compare stall detector. It keeps a per-register countdown scoreboard plus a HI/LO multiply/divide busy counter, and from those raises the ID-stage stall. It sits beside the controller, is fed by ID-stage decode, and stalls IF/ID. Its stall rules replace the hard-coded load-use, load-store and early-branch/JR compares with latency-driven rules that cover multi-cycle MD ops.

## Interface
Parameters:
- NREG, 32, number of GPRs; register 0 is hard-wired and never tracked
- RW, $clog2(NREG), register index width
- LOAD_LAT, 2, scoreboard value set by a load producer; must be at least 2
- MUL_LAT, 5, multiply occupancy of HI/LO in cycles; must be at least 1
- DIV_LAT, 32, divide occupancy of HI/LO in cycles; must be at least 1
- CW, $clog2(max(LOAD_LAT,MUL_LAT,DIV_LAT)+1), counter width

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state immediately
- id_valid  in  1  ID holds a real instruction
- flush  in  1  kill the ID instruction this cycle; no scoreboard update
- id_rs, id_rt  in  RW each  source register indices
- id_use_rs, id_use_rt  in  1 each  the source is read
- id_early  in  1  sources are consumed in ID (branch compare or JR/JALR)
- id_store_rt  in  1  rt is store data only (consumed at MEM)
- id_regwrite  in  1  instruction writes id_rw
- id_rw  in  RW  destination index
- id_class  in  2  producer class: 0 ALU, 1 load, 2 mul, 3 div
- id_reads_hilo  in  1  MFHI/MFLO
- stall  out  1  hold IF/ID and bubble EX
- stall_reason  out  2  [0] GPR hazard, [1] HI/LO hazard
- md_busy  out  1  HI/LO unit occupied
- md_cnt_o  out  CW  remaining MD cycles, for debug

## Operation
- State: cnt[1..NREG-1] (CW bits each) and md_cnt (CW bits). All reset to 0.
- Issue condition: `issue = id_valid & !flush & !stall`.
- GPR producer rule: on issue with id_regwrite and id_rw != 0, set cnt[id_rw] on the next edge:
  - ALU class or MFHI/MFLO: 1
  - load class: LOAD_LAT
- MD producer rule: on issue with class 2 or 3, set md_cnt to MUL_LAT or DIV_LAT. MD ops write no GPR; id_regwrite is ignored for classes 2 and 3.
- Decrement: every other nonzero cnt and md_cnt decrements by 1 each cycle, saturating at 0. If an issue and a decrement target the same entry in one cycle, the issue write wins.
- GPR hazard per used source s with index != 0. Thresholds on cnt[s]:
  - id_early: hazard if cnt > 0
  - rt with id_store_rt and not id_early: hazard if cnt > LOAD_LAT (load in EX, store in ID bypasses at MEM)
  - otherwise: hazard if cnt > 1
- HI/LO hazard: md_busy and (id_reads_hilo or class 2/3). Back-to-back MD ops serialise.
- stall = id_valid & !flush & (GPR hazard | HI/LO hazard); stall_reason mirrors the terms. stall is combinational from the inputs and state.
- While stalled, no scoreboard write occurs; counters keep decrementing.
- flush does not cancel in-flight MD ops; md_cnt continues (MIPS HI/LO semantics).
- md_busy = (md_cnt != 0); md_cnt_o = md_cnt.

## Timing
- Reset: stall=0, stall_reason=0, md_busy=0, md_cnt_o=0, all cnt=0. Asserting rst mid-operation clears state asynchronously, and outputs fall in the same cycle.
- Load-use: a consumer in the cycle right after a load issue stalls exactly 1 cycle (non-early) or 2 cycles (early).
- An ALU producer followed by an early consumer stalls 1 cycle; a non-early consumer does not stall.
- HI/LO: after an MD issue at edge t, MFHI/MFLO stalls until md_cnt reaches 0 and issues at edge t+LAT.
- Simultaneous MD completion (md_cnt=1) and a new MD request: the request stalls that cycle and issues next cycle.

## Test plan
- `lw $3` issued at cycle 0, `add $4,$3,$1` in ID at cycle 1 -> stall=1, reason=01 at cycle 1; stall=0 at cycle 2 and the add issues.
- `lw $3`, then `sw $3,0($2)` (id_store_rt=1) next cycle -> stall=0 throughout.
- `add $5`, then `beq $5,$0` (id_early=1) -> 1 stall cycle; repeat with `lw $5` -> 2 stall cycles.
- `div` with DIV_LAT=32, then `mflo` held in ID -> md_busy=1 for 32 cycles, stall reason=10 for 32 cycles, mflo issues at edge 32; a `mult` in place of mflo behaves identically.
- `lw $0`, then `add` reading $0 -> no stall; cnt stays 0.
- Mid-div (md_cnt=17), pulse rst asynchronously -> md_busy and stall drop to 0 before the next clock edge; the first instruction after reset issues without stall.
